// File: rtl/ps2_pkg.sv
// Scan code set 2 constants, direction encodings and decoder FSM states.
// Shared by ps2_key_decoder and ps2_dir_arbiter.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    // Direction code doubles as the bit index into key_held.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_e;

    function automatic logic [1:0] prio_dir(input logic [3:0] held);
        if (held[0]) return DIR_UP;
        else if (held[1]) return DIR_DOWN;
        else if (held[2]) return DIR_LEFT;
        else return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/ps2_dir_arbiter.sv
// Last-pressed-wins direction register with priority fallback on release.
// held is the next-cycle held vector, so dir and dir_valid track key_held.
module ps2_dir_arbiter
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] held,
    input  logic       make_vld,
    input  logic [1:0] make_dir,
    input  logic       rel_vld,
    output logic [1:0] dir,
    output logic       dir_valid
);

    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic       dir_valid_q;
    logic       dir_valid_d;

    always_comb begin
        dir_d       = dir_q;
        dir_valid_d = |held;
        if (make_vld) begin
            dir_d = make_dir;
        end else if (rel_vld && !held[dir_q] && (|held)) begin
            dir_d = prio_dir(held);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q       <= DIR_UP;
            dir_valid_q <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
        end
    end

    assign dir       = dir_q;
    assign dir_valid = dir_valid_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set 2 make/break decoder for game keys, arrows plus Enter/P.
// Define PS2_WASD_EN to also map W/A/S/D onto the four directions.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 200000,
    parameter int CNT_W          = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ack,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic [3:0] key_held,
    output logic       start_pulse,
    output logic       pause_pulse,
    output logic       seq_error
);

    ps2_state_e       state_q;
    ps2_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rx_ack_q;
    logic             rx_ack_d;
    logic             seq_error_q;
    logic             seq_error_d;
    logic [3:0]       arrow_held_q;
    logic [3:0]       arrow_held_d;
    logic             enter_held_q;
    logic             enter_held_d;
    logic             p_held_q;
    logic             p_held_d;
    logic             start_pulse_q;
    logic             start_pulse_d;
    logic             pause_pulse_q;
    logic             pause_pulse_d;

    logic             accept;
    logic             make_ev;
    logic             brk_ev;
    logic             ext_ev;
    logic             dir_hit;
    logic             arrow_hit;
    logic [1:0]       dir_idx;
    logic [3:0]       held_next;

`ifdef PS2_WASD_EN
    logic [3:0]       wasd_held_q;
    logic [3:0]       wasd_held_d;
    logic             wasd_hit;
`endif

    // rx_valid stays high through the ack cycle, so it is masked then.
    assign accept   = rx_valid && !rx_ack_q;
    assign rx_ack_d = accept;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seq_error_d = seq_error_q;
        make_ev     = 1'b0;
        brk_ev      = 1'b0;
        ext_ev      = 1'b0;
        if (accept) begin
            cnt_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_EXT) state_d = ST_EXT;
                    else if (rx_data == SC_BRK) state_d = ST_BRK;
                    else make_ev = 1'b1;
                end
                ST_EXT: begin
                    if (rx_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data != SC_EXT) begin
                        make_ev = 1'b1;
                        ext_ev  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (rx_data == SC_EXT || rx_data == SC_BRK) begin
                        seq_error_d = 1'b1;
                    end else begin
                        brk_ev = 1'b1;
                        ext_ev = (state_q == ST_EXT_BRK);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_W'(PREFIX_TIMEOUT)) begin
                state_d     = ST_IDLE;
                seq_error_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        dir_hit = 1'b0;
        dir_idx = DIR_UP;
`ifdef PS2_WASD_EN
        wasd_hit = 1'b0;
`endif
        if ((make_ev || brk_ev) && ext_ev) begin
            unique case (rx_data)
                SC_UP:    begin dir_hit = 1'b1; dir_idx = DIR_UP;    end
                SC_DOWN:  begin dir_hit = 1'b1; dir_idx = DIR_DOWN;  end
                SC_LEFT:  begin dir_hit = 1'b1; dir_idx = DIR_LEFT;  end
                SC_RIGHT: begin dir_hit = 1'b1; dir_idx = DIR_RIGHT; end
                default:  ;
            endcase
        end
`ifdef PS2_WASD_EN
        else if (make_ev || brk_ev) begin
            unique case (rx_data)
                SC_W:    begin wasd_hit = 1'b1; dir_idx = DIR_UP;    end
                SC_S:    begin wasd_hit = 1'b1; dir_idx = DIR_DOWN;  end
                SC_A:    begin wasd_hit = 1'b1; dir_idx = DIR_LEFT;  end
                SC_D:    begin wasd_hit = 1'b1; dir_idx = DIR_RIGHT; end
                default: ;
            endcase
            dir_hit = wasd_hit;
        end
        arrow_hit = dir_hit && !wasd_hit;
`else
        arrow_hit = dir_hit;
`endif
    end

    always_comb begin
        arrow_held_d  = arrow_held_q;
        enter_held_d  = enter_held_q;
        p_held_d      = p_held_q;
        start_pulse_d = 1'b0;
        pause_pulse_d = 1'b0;
        if (arrow_hit) arrow_held_d[dir_idx] = make_ev;
        if ((make_ev || brk_ev) && !ext_ev) begin
            if (rx_data == SC_ENTER) begin
                enter_held_d  = make_ev;
                start_pulse_d = make_ev && !enter_held_q;
            end
            if (rx_data == SC_P) begin
                p_held_d      = make_ev;
                pause_pulse_d = make_ev && !p_held_q;
            end
        end
    end

`ifdef PS2_WASD_EN
    always_comb begin
        wasd_held_d = wasd_held_q;
        if (wasd_hit) wasd_held_d[dir_idx] = make_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) wasd_held_q <= '0;
        else     wasd_held_q <= wasd_held_d;
    end

    assign held_next = arrow_held_d | wasd_held_d;
    assign key_held  = arrow_held_q | wasd_held_q;
`else
    assign held_next = arrow_held_d;
    assign key_held  = arrow_held_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rx_ack_q      <= 1'b0;
            seq_error_q   <= 1'b0;
            arrow_held_q  <= '0;
            enter_held_q  <= 1'b0;
            p_held_q      <= 1'b0;
            start_pulse_q <= 1'b0;
            pause_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_ack_q      <= rx_ack_d;
            seq_error_q   <= seq_error_d;
            arrow_held_q  <= arrow_held_d;
            enter_held_q  <= enter_held_d;
            p_held_q      <= p_held_d;
            start_pulse_q <= start_pulse_d;
            pause_pulse_q <= pause_pulse_d;
        end
    end

    ps2_dir_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .held      (held_next),
        .make_vld  (make_ev && dir_hit),
        .make_dir  (dir_idx),
        .rel_vld   (brk_ev && dir_hit),
        .dir       (dir),
        .dir_valid (dir_valid)
    );

    assign rx_ack      = rx_ack_q;
    assign start_pulse = start_pulse_q;
    assign pause_pulse = pause_pulse_q;
    assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed table bench for ps2_key_decoder, plus timeout and ack sequences.
// Build with PS2_WASD_EN defined to exercise the W/A/S/D vectors.
module tb_ps2_key_decoder;

    localparam int PT = 40;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_F0   = 2'b01;
    localparam logic [1:0] P_E0   = 2'b10;
    localparam logic [1:0] P_EB   = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ack;
    logic [1:0] dir;
    logic       dir_valid;
    logic [3:0] key_held;
    logic       start_pulse;
    logic       pause_pulse;
    logic       seq_error;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst_b;
        logic [7:0] data;
        logic [3:0] held;
        logic [1:0] dir;
        logic       dv;
        logic       st;
        logic       pa;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    ps2_key_decoder #(
        .PREFIX_TIMEOUT (PT),
        .CNT_W          (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .dir         (dir),
        .dir_valid   (dir_valid),
        .key_held    (key_held),
        .start_pulse (start_pulse),
        .pause_pulse (pause_pulse),
        .seq_error   (seq_error)
    );

    always #5 clk = ~clk;

    function automatic void push(logic r, logic [7:0] d, logic [3:0] h,
                                 logic [1:0] di, logic dv, logic st,
                                 logic pa, logic er);
        vec_t v;
        v.rst_b = r; v.data = d; v.held = h; v.dir = di;
        v.dv = dv; v.st = st; v.pa = pa; v.er = er;
        vecs.push_back(v);
    endfunction

    // Prefix bytes expect the previous visible state with no pulses.
    function automatic void add(logic r, logic [1:0] pre, logic [7:0] d,
                                logic [3:0] h, logic [1:0] di, logic dv,
                                logic st, logic pa, logic er);
        vec_t p;
        logic rr;
        rr = r;
        if (r || vecs.size() == 0) begin
            p.held = '0; p.dir = '0; p.dv = 1'b0; p.er = 1'b0;
        end else begin
            p = vecs[vecs.size()-1];
        end
        if (pre[1]) begin
            push(rr, 8'hE0, p.held, p.dir, p.dv, 1'b0, 1'b0, p.er);
            rr = 1'b0;
        end
        if (pre[0]) begin
            push(rr, 8'hF0, p.held, p.dir, p.dv, 1'b0, 1'b0, p.er);
            rr = 1'b0;
        end
        push(rr, d, h, di, dv, st, pa, er);
    endfunction

    task automatic check(input string name, input logic [10:0] act,
                         input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset", {rx_ack, key_held, dir, dir_valid, start_pulse,
                        pause_pulse, seq_error}, 11'd0);
    endtask

    // Valid stays high through the ack cycle, as the real receiver does.
    task automatic send_byte(input logic [7:0] b, output logic [9:0] snap);
        logic got;
        got  = 1'b0;
        snap = '0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        snap = {key_held, dir, dir_valid, start_pulse, pause_pulse, seq_error};
        check($sformatf("ack_rise_%h", b), {10'd0, got}, 11'd1);
        @(posedge clk);
        #1;
        check($sformatf("ack_once_%h", b), {10'd0, rx_ack}, 11'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin : main
        logic [9:0] snap;

        add(1, P_E0, 8'h75, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_E0, 8'h6B, 4'h5, 2'd2, 1, 0, 0, 0);
        add(0, P_EB, 8'h6B, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_EB, 8'h75, 4'h0, 2'd0, 0, 0, 0, 0);
        add(0, P_E0, 8'h75, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_E0, 8'h74, 4'h9, 2'd3, 1, 0, 0, 0);
        add(0, P_EB, 8'h74, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_EB, 8'h75, 4'h0, 2'd0, 0, 0, 0, 0);
        add(0, P_E0, 8'h74, 4'h8, 2'd3, 1, 0, 0, 0);
        add(0, P_E0, 8'h72, 4'hA, 2'd1, 1, 0, 0, 0);
        add(0, P_E0, 8'h6B, 4'hE, 2'd2, 1, 0, 0, 0);
        add(0, P_EB, 8'h6B, 4'hA, 2'd1, 1, 0, 0, 0);
        add(0, P_EB, 8'h72, 4'h8, 2'd3, 1, 0, 0, 0);
        add(0, P_EB, 8'h74, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_EB, 8'h75, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h75, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h6B, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h5A, 4'h0, 2'd3, 0, 1, 0, 0);
        add(0, P_NONE, 8'h5A, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h5A, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_F0, 8'h5A, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h5A, 4'h0, 2'd3, 0, 1, 0, 0);
        add(0, P_NONE, 8'h4D, 4'h0, 2'd3, 0, 0, 1, 0);
        add(0, P_NONE, 8'h4D, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_F0, 8'h4D, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h4D, 4'h0, 2'd3, 0, 0, 1, 0);
        add(0, P_NONE, 8'hAA, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'hFA, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'hFE, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h00, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'hFF, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'hE1, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_E0, 8'hE0, 4'h0, 2'd3, 0, 0, 0, 0);
        add(0, P_NONE, 8'h74, 4'h8, 2'd3, 1, 0, 0, 0);
        add(0, P_E0, 8'h75, 4'h9, 2'd0, 1, 0, 0, 0);
        add(0, P_E0, 8'h74, 4'h9, 2'd3, 1, 0, 0, 0);
        add(0, P_F0, 8'hE0, 4'h9, 2'd3, 1, 0, 0, 1);
        add(0, P_NONE, 8'h74, 4'h9, 2'd3, 1, 0, 0, 1);
        add(0, P_EB, 8'hF0, 4'h9, 2'd3, 1, 0, 0, 1);
        add(0, P_EB, 8'h74, 4'h1, 2'd0, 1, 0, 0, 1);
        add(1, P_NONE, 8'hE0, 4'h0, 2'd0, 0, 0, 0, 0);
        add(1, P_NONE, 8'h75, 4'h0, 2'd0, 0, 0, 0, 0);
        add(0, P_NONE, 8'hF0, 4'h0, 2'd0, 0, 0, 0, 0);
        add(1, P_NONE, 8'h5A, 4'h0, 2'd0, 0, 1, 0, 0);
`ifdef PS2_WASD_EN
        add(1, P_NONE, 8'h1D, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_F0, 8'h1D, 4'h0, 2'd0, 0, 0, 0, 0);
        add(0, P_E0, 8'h75, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_NONE, 8'h1D, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_F0, 8'h1D, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_NONE, 8'h1C, 4'h5, 2'd2, 1, 0, 0, 0);
        add(0, P_F0, 8'h1C, 4'h1, 2'd0, 1, 0, 0, 0);
        add(0, P_NONE, 8'h1B, 4'h3, 2'd1, 1, 0, 0, 0);
        add(0, P_NONE, 8'h23, 4'hB, 2'd3, 1, 0, 0, 0);
`else
        add(1, P_NONE, 8'h1D, 4'h0, 2'd0, 0, 0, 0, 0);
        add(0, P_NONE, 8'h23, 4'h0, 2'd0, 0, 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            if (vecs[i].rst_b) do_reset();
            send_byte(vecs[i].data, snap);
            check($sformatf("vec%0d_%h", i, vecs[i].data), {1'b0, snap},
                  {1'b0, vecs[i].held, vecs[i].dir, vecs[i].dv,
                   vecs[i].st, vecs[i].pa, vecs[i].er});
        end

        // Prefix timeout: quiet just before the limit, error well after it.
        do_reset();
        send_byte(8'hE0, snap);
        check("to_e0", {1'b0, snap}, 11'd0);
        repeat (20) @(posedge clk);
        #1;
        check("to_early", {10'd0, seq_error}, 11'd0);
        repeat (40) @(posedge clk);
        #1;
        check("to_late", {10'd0, seq_error}, 11'd1);
        send_byte(8'hE0, snap);
        send_byte(8'h72, snap);
        check("to_recover", {1'b0, snap}, {1'b0, 4'h2, 2'd1, 1'b1,
                                           1'b0, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes bytes from the PS/2 receiver (8-bit data + valid, held until ack) and decodes scan code set 2 make/break sequences.
- Tracks which game keys are held.
- Produces a debounced Pac-Man direction request plus start/pause strobes for the game controller.
- Sits between the PS/2 receiver and the game-logic FSM, all in the clk domain.

Parameters:
- PREFIX_TIMEOUT, 200000: clk cycles allowed between a prefix byte (E0/F0) and its follow-up byte before the FSM abandons the sequence.
- CNT_W, 18: width of the timeout counter; must satisfy 2^CNT_W > PREFIX_TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received byte from the PS/2 receiver
- rx_valid  in  1  byte available; stays high until acknowledged
- rx_ack  out  1  one-cycle registered acknowledge to the receiver
- dir  out  2  requested direction: 00 up, 01 down, 10 left, 11 right
- dir_valid  out  1  at least one direction key is held
- key_held  out  4  {right,left,down,up} held flags
- start_pulse  out  1  one-cycle pulse on an Enter make
- pause_pulse  out  1  one-cycle pulse on a P make
- seq_error  out  1  sticky flag: timeout or illegal byte after a prefix; cleared only by rst

Behaviour:
- Reset and interface: reset is rst, synchronous, active-high; clock is clk.
- Reset values: rx_ack=0, dir=00, dir_valid=0, key_held=0, start_pulse=0, pause_pulse=0, seq_error=0, FSM=IDLE, timeout counter=0, internal enter/P held bits=0.
- Byte acceptance:
  - A byte is accepted at a clk edge where rx_valid=1 and rx_ack=0.
  - rx_ack is high for exactly the following cycle.
  - rx_valid is ignored while rx_ack=1, because the receiver clears valid one cycle after ack. This prevents double consumption.
- Latency: all outputs update on the same edge that raises rx_ack, i.e. one cycle after acceptance.
- FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0).
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a plain make, decoded, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte is an extended make, decoded, -> IDLE.
  - BRK: any byte other than E0/F0 is a plain break, decoded, -> IDLE; E0/F0 sets seq_error, -> IDLE.
  - EXT_BRK: any byte other than E0/F0 is an extended break, decoded, -> IDLE; E0/F0 sets seq_error, -> IDLE.
  - Bytes AA, FA, FE, 00, FF, E1 in IDLE are ignored with no state change.
- Key map:
  - Extended: 75 up, 72 down, 6B left, 74 right.
  - Plain: 5A Enter, 4D P.
  - Non-extended 75/72/6B/74 (keypad) are ignored.
  - All other codes are ignored.
- Timeout:
  - The counter clears on entry to EXT/BRK/EXT_BRK and increments every cycle in those states.
  - When it reaches PREFIX_TIMEOUT: -> IDLE, seq_error=1.
  - Acceptance of a byte in the same cycle takes precedence over the timeout.
- Make/break effects:
  - A make sets the key's held bit; a break clears it.
  - A break of a key that is not held is a no-op.
- Strobes:
  - start_pulse/pause_pulse fire only on a 0->1 transition of the Enter/P held bit.
  - Typematic repeats (make while already held) produce no pulse.
- Direction arbitration:
  - A direction make (including a repeat) sets dir to that key: last-pressed wins.
  - When the key equal to dir is released and other direction keys remain held, dir = highest-priority held key, priority up > down > left > right.
  - When none remain held, dir keeps its last value and dir_valid=0.
  - dir_valid = OR of key_held.
- Reset mid-sequence: discards the prefix state and all held bits; the following orphaned break byte is decoded as a plain make if it is a mapped code (no recovery is attempted).

Optional Feature:
- Macro: PS2_WASD_EN.
- Defined: plain codes 1D (W), 1B (S), 1C (A), 23 (D) also drive up/down/left/right.
  - Each has its own held bit.
  - key_held[i] = arrow_held[i] OR wasd_held[i].
  - Arbitration operates on the combined bits; releasing W while E0 75 is still held keeps up held.
- Undefined: those codes are ignored, and no extra registers are built.

Decomposition:
- Package ps2_pkg holds:
  - scan code constants (SC_EXT=E0, SC_BRK=F0, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_ENTER, SC_P, SC_W/A/S/D);
  - the DIR_UP/DOWN/LEFT/RIGHT encodings;
  - the FSM state enumeration.
- One sub-module, ps2_dir_arbiter: takes held bits plus make/release events and produces dir and dir_valid. Being combinational priority plus a dir register, it is testable on its own.

Test Plan:
- E0 75 (valid held until ack) -> exactly one rx_ack per byte; key_held=0001, dir=00, dir_valid=1.
- E0 75, E0 6B, E0 F0 6B -> dir goes 00 -> 10 -> 00; key_held ends 0001.
- E0 75, E0 74, E0 F0 74, E0 F0 75 -> dir 00, 11, 00; then dir_valid=0 with dir still 00; key_held=0000.
- 5A, 5A, 5A, F0 5A, 5A -> start_pulse exactly twice (first and last 5A); 4D behaves the same for pause_pulse.
- E0 followed by no byte for PREFIX_TIMEOUT cycles -> FSM back in IDLE, seq_error=1; a subsequent E0 72 still sets dir=01.
- rst asserted between E0 and 75 -> all outputs zero; the following 75 is ignored as keypad; with PS2_WASD_EN, 1D then F0 1D -> dir=00, dir_valid 1 then 0.
